ptat_freq_meter: RTL and testbench

//  Parametrised synchronous successor to the ripple-counter frequency-to-digital converter.

---
 rtl/ptat_freq_meter.sv | 139 +++++++++++++
 tb/tb_ptat_freq_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptat_freq_meter.sv
// rtl/ptat_freq_meter.sv - windowed edge counter for an asynchronous oscillator input
// Optional continuous back-to-back windows when FTD_CONT_EN is defined.
module ptat_freq_meter #(
  parameter int CNT_W       = 12,
  parameter int REF_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [REF_W-1:0] win_len,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic [CNT_W+1:0] io_oeb
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;
  localparam logic [REF_W:0]   REM_ONE = 1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;
  logic [REF_W:0]         rem_q, rem_d;
  logic [REF_W:0]         win_q, win_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       acc_sat;
  logic                   sat_now;
  logic [REF_W:0]         win_full;
  logic                   reload;

  // Edge flop runs in every state so MEAS entry never sees a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], f_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign sat_now  = rise & (acc_q == ACC_MAX);
  assign acc_sat  = (acc_q == ACC_MAX) ? ACC_MAX : acc_q + {{(CNT_W-1){1'b0}}, rise};
  assign win_full = (win_len == '0) ? {1'b1, {REF_W{1'b0}}} : {1'b0, win_len};

`ifdef FTD_CONT_EN
  assign reload = cont;
`else
  logic unused_cont;
  assign unused_cont = cont;
  assign reload      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    win_d     = win_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = win_full;
          win_d     = win_full;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = MEAS;
        end
      end
      MEAS: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rem_q == REM_ONE) begin
          count_d = acc_sat;
          ovf_d   = ovf_acc_q | sat_now;
          done_d  = 1'b1;
          if (reload) begin
            // Next window starts immediately; this cycle's edge belongs to the finished one.
            rem_d     = win_q;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          acc_d     = acc_sat;
          ovf_acc_d = ovf_acc_q | sat_now;
          rem_d     = rem_q - REM_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q == MEAS);
  assign done   = done_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign io_oeb = '0;

endmodule

// File: tb/tb_ptat_freq_meter.sv
// tb/tb_ptat_freq_meter.sv - self-checking bench for ptat_freq_meter (default and CNT_W=4 instances)
module tb_ptat_freq_meter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, start, stop, cont, f_in;
  logic [7:0]  win_len;
  logic        busy, done, ovf, busy4, done4, ovf4;
  logic [11:0] count;
  logic [3:0]  count4;
  logic [13:0] oeb;
  logic [5:0]  oeb4;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int per = 0;
  int ph = 0;
  bit rnd_mode = 0;
  bit fsamp [0:39999];

  ptat_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .win_len(win_len),
    .f_in(f_in), .busy(busy), .done(done), .count(count), .ovf(ovf), .io_oeb(oeb));

  ptat_freq_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .win_len(win_len),
    .f_in(f_in), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4), .io_oeb(oeb4));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cyc < 40000) fsamp[cyc] <= f_in;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rnd_mode) f_in = 1'($urandom_range(0, 1));
    else if (per == 0) f_in = 1'b0;
    else f_in = ((ph % per) < (per / 2));
    ph++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Rising edges of the sampled input whose synchronised edge lands in the window.
  function automatic int model_rises(input int p, input int n);
    int r = 0;
    for (int m = p + 1; m <= p + n; m++)
      if (fsamp[m - S] && !fsamp[m - S - 1]) r++;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic measure(input logic [7:0] w, output int lat, output int bcyc, output int ndone,
                         output logic [11:0] c, output logic o, output logic [3:0] c4,
                         output logic o4, output int p);
    int n;
    n = (w == 0) ? 256 : int'(w);
    @(negedge clk);
    start = 1'b1; win_len = w; p = cyc;
    lat = -1; bcyc = 0; ndone = 0; c = 'x; o = 'x; c4 = 'x; o4 = 'x;
    for (int k = 1; k <= n + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) win_len = 8'($urandom);
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; c = count; o = ovf; end
      end
      if (done4) begin c4 = count4; o4 = ovf4; end
    end
  endtask

  typedef struct {
    logic [7:0] w;
    int per;
    int exp_c;
    int exp_c4;
    bit exp_o4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, bc, nd, p, n, r, k, kd;
    logic [11:0] c;
    logic [3:0] c4;
    logic o, o4;
    int dt[$];
    int dc[$];

    vecs[0] = '{8'd100, 10, 10, 10, 1'b0};
    vecs[1] = '{8'd0,    8, 32, 15, 1'b1};
    vecs[2] = '{8'd0,    0,  0,  0, 1'b0};
    vecs[3] = '{8'd100,  4, 25, 15, 1'b1};
    vecs[4] = '{8'd32,   4,  8,  8, 1'b0};
    vecs[5] = '{8'd40,   5,  8,  8, 1'b0};
    vecs[6] = '{8'd255,  5, 51, 15, 1'b1};

    rst = 1'b1; start = 0; stop = 0; cont = 0; win_len = 0;
    idle(3);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset count", count, 0);
    check("reset ovf", ovf, 0);
    check("io_oeb", oeb, 0);
    rst = 1'b0;
    idle(3);

    foreach (vecs[i]) begin
      per = vecs[i].per;
      idle(20);
      n = (vecs[i].w == 0) ? 256 : int'(vecs[i].w);
      measure(vecs[i].w, lat, bc, nd, c, o, c4, o4, p);
      check($sformatf("v%0d latency", i), lat, n + 1);
      check($sformatf("v%0d busy cycles", i), bc, n);
      check($sformatf("v%0d done count", i), nd, 1);
      check($sformatf("v%0d count", i), c, vecs[i].exp_c);
      check($sformatf("v%0d ovf", i), o, 0);
      check($sformatf("v%0d count4", i), c4, vecs[i].exp_c4);
      check($sformatf("v%0d ovf4", i), o4, vecs[i].exp_o4);
      check($sformatf("v%0d io_oeb4", i), oeb4, 0);
    end

    rnd_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'($urandom_range(1, 120));
      measure(w, lat, bc, nd, c, o, c4, o4, p);
      r = model_rises(p, int'(w));
      check($sformatf("rnd%0d latency", i), lat, int'(w) + 1);
      check($sformatf("rnd%0d count", i), c, (r > 4095) ? 4095 : r);
      check($sformatf("rnd%0d ovf", i), o, (r > 4095) ? 1 : 0);
      check($sformatf("rnd%0d count4", i), c4, (r > 15) ? 15 : r);
      check($sformatf("rnd%0d ovf4", i), o4, (r > 15) ? 1 : 0);
    end
    rnd_mode = 0;

    per = 10;
    idle(20);
    measure(8'd100, lat, bc, nd, c, o, c4, o4, p);
    check("pre-stop count", c, 10);
    @(negedge clk); start = 1; win_len = 100;
    @(negedge clk); start = 0;
    idle(49);
    stop = 1;
    @(negedge clk); stop = 0;
    check("stop busy drop", busy, 0);
    nd = 0;
    for (int i = 0; i < 110; i++) begin @(negedge clk); if (done) nd++; end
    check("stop no done", nd, 0);
    check("stop count held", count, 10);

    stop = 1;
    idle(2);
    check("stop in idle", busy, 0);
    start = 1; win_len = 30;
    @(negedge clk); start = 0; stop = 0;
    check("start beats stop", busy, 1);
    kd = -1;
    for (int i = 2; i <= 60; i++) begin @(negedge clk); if (done && kd < 0) kd = i; end
    check("start&stop latency", kd, 31);
    check("start&stop count", count, 3);

    per = 4;
    idle(10);
    @(negedge clk); start = 1; win_len = 20;
    kd = -1;
    for (int i = 1; i <= 40 && kd < 0; i++) begin
      @(negedge clk); start = 0;
      if (done) kd = i;
    end
    check("b2b first done", kd, 21);
    start = 1;
    kd = -1;
    for (int i = 1; i <= 40 && kd < 0; i++) begin
      @(negedge clk); start = 0;
      if (done) kd = i;
    end
    check("b2b second latency", kd, 21);
    check("b2b second count", count, 5);

    per = 10;
    @(negedge clk); start = 1; win_len = 100;
    @(negedge clk); start = 0;
    idle(29);
    rst = 1;
    @(negedge clk); rst = 0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst count", count, 0);
    check("rst ovf", ovf, 0);
    check("rst count4", count4, 0);

    idle(5);
    @(negedge clk); start = 1; win_len = 40;
    nd = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (done) nd++;
    end
    start = 0;
    check("start in meas one done", nd, 1);

    per = 5;
    idle(20);
    cont = 1;
    @(negedge clk); start = 1; win_len = 40;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      start = 0;
      if (i == 100) cont = 0;
      if (done) begin dt.push_back(i); dc.push_back(int'(count)); end
    end
    cont = 0;
`ifdef FTD_CONT_EN
    check("cont done count", dt.size(), 3);
    for (k = 0; k < dt.size() && k < 3; k++) begin
      check($sformatf("cont done %0d time", k), dt[k], 41 + 40 * k);
      check($sformatf("cont done %0d count", k), dc[k], 8);
    end
`else
    check("cont ignored done count", dt.size(), 1);
    if (dt.size() > 0) begin
      check("cont ignored time", dt[0], 41);
      check("cont ignored count", dc[0], 8);
    end
`endif
    check("cont end busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
